tl_phase_timer: RTL and testbench
=================================

# tl_phase_timer

Upstream sequencer for the traffic-light controller: drives its `start`, `en` and `ryg` inputs and watches its `red`/`yellow`/`green` outputs. It launches the controller into a chosen first phase. It then times each phase with a per-phase dwell counter and issues a one-cycle `en` to advance the controller. It stops with a sticky fault if the lamp feedback is illegal.

## Interface
- `RED_CYC`, default 20: dwell of RED, in cycles (≥2)
- `RY_CYC`, default 3: dwell of RED_YELLOW (≥2)
- `GREEN_CYC`, default 20: dwell of GREEN (≥2)
- `YELLOW_CYC`, default 4: dwell of YELLOW (≥2)
- `CNT_W`, default 8: dwell counter width; every dwell ≤ 2^CNT_W
- `ACK_TIMEOUT`, default 8: WAIT_ACK limit in cycles; used only with the macro below
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `go` in 1: request to launch a sequence (sampled in IDLE)
- `init_ryg` in 3: first phase requested; legal values 100, 110, 001, 010
- `halt` in 1: freeze phase timing while high
- `clr` in 1: leave FAULT
- `red`, `yellow`, `green` in 1 each: lamp feedback from the controller
- `start` out 1: controller start
- `en` out 1: controller enable / advance strobe
- `ryg` out 3: controller initial-phase select
- `busy` out 1: state ≠ IDLE
- `fault` out 1: state = FAULT

## Operation
- Lamp vector L = {red, yellow, green}.
- Legal L values: 100 (RED), 110 (RED_YELLOW), 001 (GREEN), 010 (YELLOW). Anything else is illegal.
- dur(L): RED_CYC, RY_CYC, GREEN_CYC, YELLOW_CYC respectively.
- **IDLE**: all outputs 0; `cnt` = 0.
  - `go`=1 with legal `init_ryg` → ARM; `init_ryg` is captured into `ryg_q`.
  - `go` with illegal `init_ryg` is ignored (stay IDLE).
- **ARM** (exactly 1 cycle): `start`=1, `en`=1, `ryg`=`ryg_q` → WAIT_ACK.
- **WAIT_ACK**: `start`=`en`=0, `ryg`=`ryg_q`.
  - L legal → RUN, `cnt` ← 1. This cycle counts as phase cycle 0.
  - L illegal and ≠000 → FAULT.
- **RUN**:
  - `en` = (`cnt` == dur(L)−1) && !`halt`, combinational from registered state.
  - Phase counting: if `en`, `cnt` ← 0; else if !`halt`, `cnt` ← `cnt`+1; else `cnt` holds.
  - L illegal (including 000) → FAULT, `en` forced 0.
  - `go` is ignored.
- **FAULT**: sticky; `en`=`start`=0, `fault`=1, `ryg`=000. `clr`=1 → IDLE next cycle.
- `clr` is ignored outside FAULT.
- `halt` is ignored outside RUN.

## Timing
- Reset (async assert, sync release): state IDLE, `cnt`=0, `ryg_q`=000. All outputs 0.
- Launch timeline: `go` seen at edge k → ARM in cycle k+1 → WAIT_ACK in cycle k+2.
  - With a compliant controller, L is legal in WAIT_ACK.
  - First `en` of RUN occurs dur(first phase)−1 cycles after the WAIT_ACK cycle.
- Each phase shows on L for exactly dur(L) cycles when `halt`=0; `en` is high in the last of them.
  - The controller advances on that edge and L changes the next cycle, where `cnt`=0.
- `halt` stretches the current phase by the number of cycles it is high.
  - If `halt` drops while `cnt`==dur−1, `en` fires in that same cycle.
- Simultaneous illegal L and `en` condition: FAULT wins; `en`=0.
- Counter never wraps: it reloads at dur−1 ≤ 2^CNT_W−1.
- `rst` mid-phase: immediate return to IDLE; `en` deasserts asynchronously.

## Configuration
- `TL_PHASE_TIMER_ACK_TIMEOUT_EN` defined:
  - WAIT_ACK counts cycles.
  - If L stays 000 for ACK_TIMEOUT cycles → FAULT.
- Not defined: WAIT_ACK waits indefinitely for legal L; `ACK_TIMEOUT` is unused.

## Test plan
- Reset then `go`=1, `init_ryg`=100, default params, compliant controller model:
  - `start`/`en` high 1 cycle.
  - Then `en` pulses after 20, 3, 20, 4 cycle phases: RED→RY→GREEN→YELLOW→RED.
- `go`=1, `init_ryg`=011 → stays IDLE, `busy`=0, no `start`.
- In GREEN at `cnt`=5, `halt` high 7 cycles → GREEN lasts 27 cycles; `en` exactly once.
- Force L=101 during RUN → next cycle `fault`=1, `en`=0. `clr` pulse → IDLE, `busy`=0.
- Macro defined, controller model never responds, ACK_TIMEOUT=8 → `fault`=1 8 cycles after entering WAIT_ACK.
  - Macro undefined: still WAIT_ACK after 100 cycles.
- Assert `rst` asynchronously mid-RED with `cnt`=10 → `en`, `busy` go 0 before the next edge.
  - After release, `go` relaunches cleanly.

Source files
------------

// File: rtl/tl_phase_timer.sv
// rtl/tl_phase_timer.sv - phase dwell sequencer for the traffic-light controller (optional macro TL_PHASE_TIMER_ACK_TIMEOUT_EN)
module tl_phase_timer #(
  parameter int RED_CYC     = 20,
  parameter int RY_CYC      = 3,
  parameter int GREEN_CYC   = 20,
  parameter int YELLOW_CYC  = 4,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [2:0] init_ryg,
  input  logic       halt,
  input  logic       clr,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  output logic       start,
  output logic       en,
  output logic [2:0] ryg,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RUN      = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_RY     = 3'b110;
  localparam logic [2:0] L_GREEN  = 3'b001;
  localparam logic [2:0] L_YELLOW = 3'b010;

  // Last cycle index of each phase; the counter reloads here so it never wraps.
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYC - 1);
  localparam logic [CNT_W-1:0] RY_LAST     = CNT_W'(RY_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);

  localparam int              ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

`ifdef TL_PHASE_TIMER_ACK_TIMEOUT_EN
  localparam bit ACK_TO_ON = 1'b1;
`else
  // Without the timeout the ack counter never influences the state and folds away.
  localparam bit ACK_TO_ON = 1'b0;
`endif

  function automatic logic is_legal(input logic [2:0] v);
    return (v == L_RED) || (v == L_RY) || (v == L_GREEN) || (v == L_YELLOW);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ryg_q, ryg_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;

  logic [2:0]       lamp;
  logic             lamp_legal;
  logic             lamp_dark;
  logic [CNT_W-1:0] dur_last;

  assign lamp       = {red, yellow, green};
  assign lamp_legal = is_legal(lamp);
  assign lamp_dark  = (lamp == 3'b000);

  // Select the dwell limit of the phase currently shown on the lamps.
  always_comb begin
    dur_last = '0;
    case (lamp)
      L_RED:    dur_last = RED_LAST;
      L_RY:     dur_last = RY_LAST;
      L_GREEN:  dur_last = GREEN_LAST;
      L_YELLOW: dur_last = YELLOW_LAST;
      default:  dur_last = '0;
    endcase
  end

  // State, dwell counter, captured phase select and ack counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ryg_q     <= 3'b000;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ryg_q     <= ryg_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  // Next-state and output decode; outputs depend only on registered state plus live lamp/halt.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ryg_d     = ryg_q;
    ack_cnt_d = ack_cnt_q;
    start     = 1'b0;
    en        = 1'b0;
    ryg       = 3'b000;
    busy      = 1'b1;
    fault     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy  = 1'b0;
        cnt_d = '0;
        if (go && is_legal(init_ryg)) begin
          state_d = S_ARM;
          ryg_d   = init_ryg;
        end
      end

      S_ARM: begin
        start     = 1'b1;
        en        = 1'b1;
        ryg       = ryg_q;
        ack_cnt_d = '0;
        state_d   = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        ryg = ryg_q;
        if (lamp_legal) begin
          // This cycle is already cycle 0 of the first phase.
          state_d = S_RUN;
          cnt_d   = CNT_W'(1);
        end else if (!lamp_dark) begin
          state_d = S_FAULT;
        end else if (ACK_TO_ON && (ack_cnt_q == ACK_LAST)) begin
          state_d = S_FAULT;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        ryg = ryg_q;
        if (!lamp_legal) begin
          // Bad feedback overrides any pending advance strobe.
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if ((cnt_q == dur_last) && !halt) begin
          en    = 1'b1;
          cnt_d = '0;
        end else if (!halt) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FAULT: begin
        fault = 1'b1;
        cnt_d = '0;
        if (clr) begin
          state_d = S_IDLE;
          ryg_d   = 3'b000;
        end
      end

      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tl_phase_timer.sv
// tb/tb_tl_phase_timer.sv - self-checking bench for tl_phase_timer
module tb_tl_phase_timer;

  logic       clk;
  logic       rst;
  logic       go;
  logic [2:0] init_ryg;
  logic       halt;
  logic       clr;
  logic       red, yellow, green;
  logic       start, en, busy, fault;
  logic [2:0] ryg;

  logic       force_en;
  logic       model_on;
  logic [2:0] l_force;
  logic [2:0] m_l;
  logic [2:0] lamps;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       go;
    logic [2:0] init;
    logic       halt;
    logic       clr;
    logic [2:0] lamp;
    logic [6:0] exp;   // {start, en, ryg[2:0], busy, fault}
  } vec_t;

  vec_t tbl[$];

  tl_phase_timer dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .init_ryg (init_ryg),
    .halt     (halt),
    .clr      (clr),
    .red      (red),
    .yellow   (yellow),
    .green    (green),
    .start    (start),
    .en       (en),
    .ryg      (ryg),
    .busy     (busy),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign lamps = force_en ? l_force : m_l;
  assign red    = lamps[2];
  assign yellow = lamps[1];
  assign green  = lamps[0];

  function automatic logic [2:0] next_phase(input logic [2:0] p);
    case (p)
      3'b100:  return 3'b110;
      3'b110:  return 3'b001;
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Compliant controller: loads ryg on start+en, advances on en.
  always @(posedge clk or posedge rst) begin
    if (rst)                          m_l <= 3'b000;
    else if (model_on && start && en) m_l <= ryg;
    else if (model_on && en)          m_l <= next_phase(m_l);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic g, input logic [2:0] i, input logic h,
                              input logic c, input logic [2:0] l, input logic [6:0] e);
    vec_t v;
    v.go = g; v.init = i; v.halt = h; v.clr = c; v.lamp = l; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b1; go = 1'b0; halt = 1'b0; clr = 1'b0; init_ryg = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts sampled cycles until en is seen; returns max+1 if it never comes.
  task automatic wait_en(input int max, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n <= max) begin
      @(negedge clk);
      #1;
      n++;
      if (en) seen = 1'b1;
    end
    if (!seen) n = max + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int en_cnt;
    int en_at;

    force_en = 1'b1; model_on = 1'b0; l_force = 3'b000;

    //   go  init    halt clr  lamp    start en ryg  busy fault
    add(0, 3'b000, 0, 0, 3'b000, 7'b0_0_000_0_0); // 0  reset IDLE
    add(1, 3'b011, 0, 0, 3'b000, 7'b0_0_000_0_0); // 1  illegal init ignored
    add(0, 3'b000, 0, 0, 3'b000, 7'b0_0_000_0_0); // 2  still IDLE
    add(1, 3'b010, 0, 0, 3'b000, 7'b0_0_000_0_0); // 3  launch YELLOW
    add(0, 3'b000, 0, 0, 3'b000, 7'b1_1_010_1_0); // 4  ARM
    add(0, 3'b000, 1, 0, 3'b000, 7'b0_0_010_1_0); // 5  WAIT_ACK, halt ignored
    add(0, 3'b000, 0, 0, 3'b010, 7'b0_0_010_1_0); // 6  WAIT_ACK sees YELLOW
    add(1, 3'b100, 0, 0, 3'b010, 7'b0_0_010_1_0); // 7  RUN cnt1, go ignored
    add(0, 3'b000, 0, 1, 3'b010, 7'b0_0_010_1_0); // 8  cnt2, clr ignored
    add(0, 3'b000, 1, 0, 3'b010, 7'b0_0_010_1_0); // 9  cnt3 halted
    add(0, 3'b000, 0, 0, 3'b010, 7'b0_1_010_1_0); // 10 halt drops at last cycle: en
    add(0, 3'b000, 0, 0, 3'b100, 7'b0_0_010_1_0); // 11 RED cnt0
    add(0, 3'b000, 0, 0, 3'b101, 7'b0_0_010_1_0); // 12 illegal lamps in RUN
    add(0, 3'b000, 0, 0, 3'b101, 7'b0_0_000_1_1); // 13 FAULT
    add(0, 3'b000, 0, 1, 3'b000, 7'b0_0_000_1_1); // 14 FAULT, clr
    add(0, 3'b000, 0, 0, 3'b000, 7'b0_0_000_0_0); // 15 IDLE
    add(1, 3'b100, 0, 0, 3'b000, 7'b0_0_000_0_0); // 16 launch RED
    add(0, 3'b000, 0, 0, 3'b000, 7'b1_1_100_1_0); // 17 ARM
    add(0, 3'b000, 0, 0, 3'b011, 7'b0_0_100_1_0); // 18 WAIT_ACK illegal lamps
    add(0, 3'b000, 0, 1, 3'b000, 7'b0_0_000_1_1); // 19 FAULT, clr
    add(0, 3'b000, 0, 0, 3'b000, 7'b0_0_000_0_0); // 20 IDLE
    add(1, 3'b010, 0, 0, 3'b000, 7'b0_0_000_0_0); // 21 launch YELLOW
    add(0, 3'b000, 0, 0, 3'b000, 7'b1_1_010_1_0); // 22 ARM
    add(0, 3'b000, 0, 0, 3'b010, 7'b0_0_010_1_0); // 23 WAIT_ACK
    add(0, 3'b000, 0, 0, 3'b010, 7'b0_0_010_1_0); // 24 cnt1
    add(0, 3'b000, 0, 0, 3'b010, 7'b0_0_010_1_0); // 25 cnt2
    add(0, 3'b000, 0, 0, 3'b011, 7'b0_0_010_1_0); // 26 cnt3 with illegal lamps: no en
    add(0, 3'b000, 0, 1, 3'b011, 7'b0_0_000_1_1); // 27 FAULT, clr
    add(0, 3'b000, 0, 0, 3'b000, 7'b0_0_000_0_0); // 28 IDLE

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      go = tbl[i].go; init_ryg = tbl[i].init; halt = tbl[i].halt;
      clr = tbl[i].clr; l_force = tbl[i].lamp;
      #1;
      check($sformatf("vec%0d", i), {start, en, ryg, busy, fault}, tbl[i].exp);
      @(negedge clk);
    end
    go = 1'b0; halt = 1'b0; clr = 1'b0; force_en = 1'b0;

    // Full cycle from RED with the controller model.
    model_on = 1'b1;
    do_reset();
    go = 1'b1; init_ryg = 3'b100; #1;
    check("full_idle_busy", busy, 0);
    @(negedge clk); go = 1'b0; #1;
    check("full_arm", {start, en, ryg}, 5'b11_100);
    @(negedge clk); #1;
    check("full_wait_strobes", {start, en, busy}, 3'b001);
    check("full_wait_lamp", lamps, 3'b100);
    wait_en(40, n); check("full_red_first", n, 19); check("full_red_lamp", lamps, 3'b100);
    wait_en(40, n); check("full_ry", n, 3);         check("full_ry_lamp", lamps, 3'b110);
    wait_en(40, n); check("full_green", n, 20);     check("full_green_lamp", lamps, 3'b001);
    wait_en(40, n); check("full_yellow", n, 4);     check("full_yellow_lamp", lamps, 3'b010);
    wait_en(40, n); check("full_red_again", n, 20); check("full_red2_lamp", lamps, 3'b100);

    // GREEN stretched by 7 halted cycles starting at cnt=5.
    do_reset();
    go = 1'b1; init_ryg = 3'b001;
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    en_cnt = 0; en_at = -1;
    for (int i = 1; i <= 29; i++) begin
      @(negedge clk);
      halt = (i >= 5 && i <= 11);
      #1;
      if (en) begin
        en_cnt++;
        en_at = i;
      end
    end
    halt = 1'b0;
    check("halt_en_count", en_cnt, 1);
    check("halt_en_cycle", en_at, 26);
    check("halt_next_lamp", lamps, 3'b010);

    // Controller never answers the launch.
    model_on = 1'b0;
    do_reset();
    go = 1'b1; init_ryg = 3'b100;
    @(negedge clk); go = 1'b0;
    @(negedge clk); #1;
    check("ack_wait_entry", {busy, fault}, 2'b10);
`ifdef TL_PHASE_TIMER_ACK_TIMEOUT_EN
    repeat (7) @(negedge clk);
    #1; check("ack_before_timeout", fault, 0);
    @(negedge clk); #1;
    check("ack_timeout_fault", {fault, en, ryg}, 5'b1_0_000);
`else
    repeat (100) @(negedge clk);
    #1; check("ack_still_waiting", {busy, fault, start, en, ryg}, 7'b1_0_0_0_100);
`endif

    // Asynchronous reset mid-RED, then a clean relaunch.
    model_on = 1'b1;
    do_reset();
    go = 1'b1; init_ryg = 3'b100;
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    repeat (10) @(negedge clk);
    #1; check("rst_mid_busy", {busy, en}, 2'b10);
    #2 rst = 1'b1;
    #1; check("rst_async_outputs", {start, en, ryg, busy, fault}, 7'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); go = 1'b1; init_ryg = 3'b110;
    @(negedge clk); go = 1'b0; #1;
    check("relaunch_arm", {start, en, ryg}, 5'b11_110);
    @(negedge clk); #1;
    check("relaunch_wait_lamp", lamps, 3'b110);
    wait_en(20, n); check("relaunch_ry_en", n, 2); check("relaunch_ry_lamp", lamps, 3'b110);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
